// File: rtl/tr_err_pkg.sv
// rtl/tr_err_pkg.sv - shared state encoding for the timing-error detector
package tr_err_pkg;

    localparam int unsigned TR_ERR_STATE_W = 2;

    typedef enum logic [TR_ERR_STATE_W-1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        REPORT = 2'd2
    } tr_err_state_t;

endpackage

// File: rtl/tr_err_cmp.sv
// rtl/tr_err_cmp.sv - full-width main/shadow mismatch detector with corrected-data mux
module tr_err_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] m_i,
    input  logic [WIDTH-1:0] s_i,
    output logic             mismatch_o,
    output logic [WIDTH-1:0] corr_o
);

    // The shadow copy was taken later and is trusted whenever the two disagree.
    assign mismatch_o = (m_i != s_i);
    assign corr_o     = mismatch_o ? s_i : m_i;

endmodule

// File: rtl/tr_err_detect.sv
// rtl/tr_err_detect.sv - sample/Err1/Err0 error responder; TR_ERR_CNT_EN adds a saturating error counter
module tr_err_detect
    import tr_err_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             sample,
    output logic             Err1,
    output logic             Err0,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] err_cnt
);

    tr_err_state_t    state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sample_q;
    logic             err_q, err_d;
    logic             err1_q, err1_d;
    logic             err0_q, err0_d;
    logic             rise;
    logic             mismatch;
    logic [WIDTH-1:0] corr;

    tr_err_cmp #(.WIDTH(WIDTH)) u_cmp (
        .m_i        (m_q),
        .s_i        (s_q),
        .mismatch_o (mismatch),
        .corr_o     (corr)
    );

    assign rise = sample & ~sample_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        q_d     = q_q;
        err_d   = err_q;
        err1_d  = err1_q;
        err0_d  = err0_q;
        case (state_q)
            IDLE: begin
                err1_d = 1'b0;
                err0_d = 1'b0;
                if (rise) begin
                    s_d     = d;
                    state_d = EVAL;
                end else begin
                    m_d = d;
                end
            end
            EVAL: begin
                err_d   = mismatch;
                q_d     = corr;
                err1_d  = mismatch;
                err0_d  = ~mismatch;
                state_d = REPORT;
            end
            REPORT: begin
                // Return-to-zero only once the controller has released sample.
                if (!sample) begin
                    err1_d  = 1'b0;
                    err0_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    err1_d = err_q;
                    err0_d = ~err_q;
                end
            end
            default: begin
                err1_d  = 1'b0;
                err0_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            m_q      <= '0;
            s_q      <= '0;
            q_q      <= '0;
            sample_q <= 1'b0;
            err_q    <= 1'b0;
            err1_q   <= 1'b0;
            err0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            s_q      <= s_d;
            q_q      <= q_d;
            sample_q <= sample;
            err_q    <= err_d;
            err1_q   <= err1_d;
            err0_q   <= err0_d;
        end
    end

`ifdef TR_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == EVAL && mismatch && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign Err1 = err1_q;
    assign Err0 = err0_q;
    assign q    = q_q;

endmodule

// File: tb/tb_tr_err_detect.sv
// tb/tb_tr_err_detect.sv - randomized scoreboard bench for tr_err_detect
module tb_tr_err_detect;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] d;
    logic             sample;
    logic             Err1, Err0;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] err_cnt;

    typedef struct {
        logic             err;
        logic [WIDTH-1:0] qv;
        int               cnt;
        int               dur;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_fail = 0;
    int   model_cnt = 0;
    int   dur = 0;
    logic prev_rails = 1'b0;

    tr_err_detect #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .sample  (sample),
        .Err1    (Err1),
        .Err0    (Err0),
        .q       (q),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt_val(input int c);
`ifdef TR_ERR_CNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // Expected outcome of one evaluation, from the controller-side view.
    task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int k);
        exp_t e;
        e.err = (a != b);
        e.qv  = b;
        if (e.err && model_cnt < CNT_MAX) model_cnt++;
        e.cnt = exp_cnt_val(model_cnt);
        e.dur = (k > 1) ? k - 1 : 1;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake: d=a while idle, d=b at the sample rise, sample held k cycles.
    task automatic txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int k);
        d = a;
        sample = 1'b0;
        repeat (3) tick();
        d = b;
        sample = 1'b1;
        push_exp(a, b, k);
        tick();
        d = WIDTH'($urandom);
        repeat (k - 1) tick();
        sample = 1'b0;
    endtask

    always @(negedge clk) begin
        logic rails;
        chk("rails_onehot", {31'd0, Err1 & Err0}, 32'd0);
        rails = Err1 | Err0;
        if (rails && !prev_rails) begin
            if (sb.size() == 0) begin
                chk("unexpected_report", 32'd1, 32'd0);
            end else begin
                cur = sb.pop_front();
                chk("Err1", {31'd0, Err1}, {31'd0, cur.err});
                chk("Err0", {31'd0, Err0}, {31'd0, ~cur.err});
                chk("q", {24'd0, q}, {24'd0, cur.qv});
                chk("err_cnt", {30'd0, err_cnt}, cur.cnt);
            end
            dur = 1;
        end else if (rails && prev_rails) begin
            dur++;
        end else if (!rails && prev_rails) begin
            chk("rail_duration", dur, cur.dur);
        end
        prev_rails = rails;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, pending %0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        int wait_cnt;

        rst = 1'b0;
        d = 8'hFF;
        sample = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_Err1", {31'd0, Err1}, 32'd0);
        chk("rst_Err0", {31'd0, Err0}, 32'd0);
        chk("rst_q", {24'd0, q}, 32'd0);
        chk("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
        sample = 1'b0;
        tick();
        rst = 1'b1;

        txn(8'h3C, 8'h3C, 4);
        txn(8'h3C, 8'h5A, 2);
        txn(8'h11, 8'h12, 1);
        txn(8'h80, 8'h00, 3);
        txn(8'hA5, 8'h5A, 1);
        txn(8'h01, 8'h81, 5);

        for (int i = 0; i < 24; i++) begin
            a = WIDTH'($urandom);
            b = ($urandom_range(0, 1) == 1) ? a : WIDTH'($urandom);
            txn(a, b, int'($urandom_range(1, 5)));
        end

        // Reset while an error report is being held.
        d = 8'h0F;
        sample = 1'b0;
        repeat (3) tick();
        d = 8'hF0;
        sample = 1'b1;
        push_exp(8'h0F, 8'hF0, 2);
        sb[sb.size()-1].dur = 1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        model_cnt = 0;
        @(negedge clk);
        chk("midrst_Err1", {31'd0, Err1}, 32'd0);
        chk("midrst_q", {24'd0, q}, 32'd0);
        chk("midrst_err_cnt", {30'd0, err_cnt}, 32'd0);
        rst = 1'b1;
        sample = 1'b0;

        txn(8'h77, 8'h76, 2);
        txn(8'h42, 8'h42, 3);
        d = 8'h00;

        wait_cnt = 0;
        while ((sb.size() != 0 || prev_rails) && wait_cnt < 50) begin
            tick();
            wait_cnt++;
        end
        chk("drain_pending", sb.size(), 32'd0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tr_err_detect.md
# tr_err_detect

Clocked error-detection responder for the timing-resilient pipeline stage: the other end of the controller's `sample` / `Err1` / `Err0` exchange. It captures the stage datapath output on every clock, takes a late shadow copy when the controller raises `sample`, and compares the two. It answers with a dual-rail, return-to-zero error indication, forwards the corrected data, and optionally counts timing errors.

## Interface
Parameters:
- `WIDTH`, 8: datapath width.
- `CNT_W`, 8: error-counter width (used only with `TR_ERR_CNT_EN`).

Ports:
- `clk`  in  1: stage clock, as generated by the controller; rising-edge active.
- `rst`  in  1: reset, synchronous, active-low.
- `d`  in  WIDTH: combinational datapath output of the stage.
- `sample`  in  1: controller request to evaluate errors; level signal, 4-phase.
- `Err1`  out  1: dual-rail error, true rail (timing error detected).
- `Err0`  out  1: dual-rail error, false rail (no error).
- `q`  out  WIDTH: stage output; corrected with the shadow value on error.
- `err_cnt`  out  CNT_W: saturating error count.

## Operation
- Internal registers: `m` (main, WIDTH), `s` (shadow, WIDTH), `sample_q` (1), `err` (1), and the state.
- `sample_q` is registered every cycle. A sample rise is `sample & ~sample_q`.
- States: IDLE, EVAL, REPORT.
- **IDLE**
  - `m <= d` every cycle.
  - On a sample rise: `s <= d`, then go to EVAL. `m` is not updated in this cycle.
- **EVAL** (always exactly one cycle)
  - `err <= (m != s)`.
  - `q <= (m != s) ? s : m`.
  - `Err1 <= (m != s)`, `Err0 <= (m == s)`.
  - Go to REPORT.
- **REPORT**
  - Hold `Err1`, `Err0` and `q`.
  - On a clock edge where `sample == 0`: `Err1 <= 0`, `Err0 <= 0`, go to IDLE.
- The dual rails are one-hot while in REPORT and both 0 at all other times. `Err1 & Err0` is never 1.
- Reset (`rst == 0` at an edge), from any state:
  - state IDLE.
  - `m`, `s`, `q`, `err`, `sample_q`, `Err1`, `Err0`, `err_cnt` all become 0.

## Timing
- Sample rise detected at edge N: `s` is captured at N, and the rails plus `q` become valid after edge N+1.
- Return to zero: the rails drop at the first edge after N+1 at which `sample` reads 0, i.e. one cycle after the controller drops `sample`.
- Short `sample` pulse (low again by edge N+1): EVAL still completes. The rails are high for exactly one cycle and clear at N+2.
- `sample` held high across REPORT: the rails are held. No new evaluation starts until IDLE is reached and a fresh rise is seen.
- A sample rise while in EVAL or REPORT is ignored. `sample_q` still tracks, so a level held high never re-triggers.
- Reset asserted in EVAL or REPORT: the rails are 0 after that edge and any pending report is dropped.
- Equality is full-width `WIDTH` compare. No partial or masked compare.

## Configuration
- `TR_ERR_CNT_EN` defined:
  - `err_cnt` increments by 1 at the EVAL edge when `m != s`.
  - It saturates at `2**CNT_W-1`, with no wrap.
  - It is cleared only by reset.
- `TR_ERR_CNT_EN` undefined:
  - `err_cnt` is tied to 0.
  - No counter flops are built.
  - The port stays, so the interface is stable.

## Structure
- Package `tr_err_pkg`:
  - state enum typedef `tr_err_state_t` (IDLE=2'd0, EVAL=2'd1, REPORT=2'd2).
  - the 2-bit state width constant.
- Sub-module `tr_err_cmp`: WIDTH-parameterised mismatch detector that outputs `m != s` and the corrected-data mux. Instantiated once.

## Test plan
- Reset: hold `rst=0` for 3 cycles with `d=8'hFF` and `sample=1`. Required: `Err1=Err0=0`, `q=0`, `err_cnt=0`, state IDLE.
- No error:
  - Stimulus: `d=8'h3C` stable, `sample` raised for 4 cycles.
  - Required: `Err0=1` from N+1 until one cycle after `sample` falls, `Err1=0`, `q=8'h3C`, `err_cnt` unchanged.
- Error:
  - Stimulus: `d=8'h3C` in IDLE, `d` changes to `8'h5A` in the cycle `sample` rises.
  - Required: `Err1=1`, `q=8'h5A`, `err_cnt=1` (with `TR_ERR_CNT_EN`).
- Short pulse: `sample` high for 1 cycle. Required: the rails are high for exactly 1 cycle, then both 0.
- Saturation: with `CNT_W=2`, run 5 error evaluations. Required: `err_cnt` reads 1, 2, 3, 3, 3.
- Reset mid-report: assert `rst=0` while `Err1=1`. Required: `Err1=0` and `q=0` after that edge; a `sample` rise after release gives a normal evaluation.
